// File: rtl/utim64_irq_ctrl_pkg.sv
`default_nettype none
// =============================================================================
// utim64_irq_ctrl_pkg : shared utim64 constants, FSM encoding and channel count
// Revision 1.0
// =============================================================================
package utim64_irq_ctrl_pkg;

    localparam logic L_PARAM_IRQ_IDLE = 1'b0;
    localparam logic L_PARAM_IRQ_REQ  = 1'b1;

    // Channel count shared with the comparator counter instances
    localparam int L_PARAM_DEFAULT_CH = 4;

    typedef enum logic {
        IRQ_IDLE = L_PARAM_IRQ_IDLE,
        IRQ_REQ  = L_PARAM_IRQ_REQ
    } irq_state_t;

endpackage
`default_nettype wire

// File: rtl/utim64_irq_ctrl_if.sv
`default_nettype none
// =============================================================================
// utim64_irq_ctrl_if : comparator IRQs, config/clear strobes and IRQ handshake
// Revision 1.0
// =============================================================================
interface utim64_irq_ctrl_if #(
    parameter int P_CH   = 4,
    parameter int P_NUMW = 3
);
    logic [P_CH-1:0]   iCMP_IRQ;
    logic              iCONF_WRITE;
    logic              iCONF_GLOBAL_ENA;
    logic [P_CH-1:0]   iCONF_MASK;
    logic              iCLR_WRITE;
    logic [P_CH-1:0]   iCLR_PENDING;
    logic [P_CH-1:0]   oPENDING;
    logic              oIRQ_VALID;
    logic [P_NUMW-1:0] oIRQ_NUM;
    logic              iIRQ_ACK;
`ifdef UTIM64_IRQ_OVERRUN_EN
    logic [P_CH-1:0]   oOVERRUN;
`endif

    modport slave (
        input  iCMP_IRQ, iCONF_WRITE, iCONF_GLOBAL_ENA, iCONF_MASK,
               iCLR_WRITE, iCLR_PENDING, iIRQ_ACK,
        output oPENDING, oIRQ_VALID, oIRQ_NUM
`ifdef UTIM64_IRQ_OVERRUN_EN
        , output oOVERRUN
`endif
    );

    modport master (
        output iCMP_IRQ, iCONF_WRITE, iCONF_GLOBAL_ENA, iCONF_MASK,
               iCLR_WRITE, iCLR_PENDING, iIRQ_ACK,
        input  oPENDING, oIRQ_VALID, oIRQ_NUM
`ifdef UTIM64_IRQ_OVERRUN_EN
        , input oOVERRUN
`endif
    );

endinterface
`default_nettype wire

// File: rtl/utim64_irq_prio_enc.sv
`default_nettype none
// =============================================================================
// utim64_irq_prio_enc : lowest-index-first priority encoder with any-set flag
// Revision 1.0
// =============================================================================
module utim64_irq_prio_enc #(
    parameter int P_CH   = 4,
    parameter int P_NUMW = 3
)(
    input  wire logic [P_CH-1:0]   vec,
    output logic      [P_NUMW-1:0] idx,
    output logic                   any
);

    always_comb begin
        idx = '0;
        any = |vec;
        // Descending scan so the lowest set index is the last one written
        for (int i = P_CH - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = P_NUMW'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/utim64_irq_ctrl.sv
`default_nettype none
// =============================================================================
// utim64_irq_ctrl : edge-detect/pending/mask IRQ collector with valid/ack output
// Revision 1.0 -- optional lost-event flags under UTIM64_IRQ_OVERRUN_EN
// =============================================================================
module utim64_irq_ctrl
    import utim64_irq_ctrl_pkg::*;
#(
    parameter int P_CH   = L_PARAM_DEFAULT_CH,
    parameter int P_NUMW = 3
)(
    input wire logic          iCLOCK,
    input wire logic          inRESET,
    utim64_irq_ctrl_if.slave  bus
);

    logic [P_CH-1:0]   prev;
    logic [P_CH-1:0]   pending;
    logic [P_CH-1:0]   mask;
    logic              global_ena;
    logic [P_CH-1:0]   edge_det;
    logic [P_CH-1:0]   sw_clr;
    logic [P_CH-1:0]   ack_clr;
    logic [P_CH-1:0]   req;
    irq_state_t        state;
    irq_state_t        state_nxt;
    logic [P_NUMW-1:0] irq_num;
    logic [P_NUMW-1:0] irq_num_nxt;
    logic [P_NUMW-1:0] enc_idx;
    logic              enc_any;

    assign edge_det = bus.iCMP_IRQ & ~prev;
    assign sw_clr   = bus.iCLR_WRITE ? bus.iCLR_PENDING : '0;
    assign req      = global_ena ? (pending & mask) : '0;

    utim64_irq_prio_enc #(
        .P_CH   (P_CH),
        .P_NUMW (P_NUMW)
    ) u_prio_enc (
        .vec (req),
        .idx (enc_idx),
        .any (enc_any)
    );

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            prev       <= '0;
            pending    <= '0;
            mask       <= '0;
            global_ena <= 1'b0;
        end else begin
            prev    <= bus.iCMP_IRQ;
            // Edge is OR-ed in last so a coincident clear never loses it
            pending <= (pending & ~(sw_clr | ack_clr)) | edge_det;
            if (bus.iCONF_WRITE) begin
                mask       <= bus.iCONF_MASK;
                global_ena <= bus.iCONF_GLOBAL_ENA;
            end
        end
    end

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            state   <= IRQ_IDLE;
            irq_num <= '0;
        end else begin
            state   <= state_nxt;
            irq_num <= irq_num_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        irq_num_nxt = irq_num;
        ack_clr     = '0;
        case (state)
            IRQ_IDLE: begin
                if (enc_any) begin
                    state_nxt   = IRQ_REQ;
                    irq_num_nxt = enc_idx;
                end
            end
            IRQ_REQ: begin
                // Once raised, only an ack retires the request
                if (bus.iIRQ_ACK) begin
                    state_nxt = IRQ_IDLE;
                    for (int i = 0; i < P_CH; i++) begin
                        ack_clr[i] = (irq_num == P_NUMW'(i));
                    end
                end
            end
            default: state_nxt = IRQ_IDLE;
        endcase
    end

    assign bus.oPENDING   = pending;
    assign bus.oIRQ_VALID = (state == IRQ_REQ);
    assign bus.oIRQ_NUM   = irq_num;

`ifdef UTIM64_IRQ_OVERRUN_EN
    logic [P_CH-1:0] overrun;

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            overrun <= '0;
        end else begin
            overrun <= (overrun & ~sw_clr) | (edge_det & pending & ~(sw_clr | ack_clr));
        end
    end

    assign bus.oOVERRUN = overrun;
`endif

endmodule
`default_nettype wire

// File: tb/tb_utim64_irq_ctrl.sv
`default_nettype none
// =============================================================================
// tb_utim64_irq_ctrl : directed vector table plus reset and lost-event sequences
// Revision 1.0
// =============================================================================
module tb_utim64_irq_ctrl;

    logic clk;
    logic rst_n;

    utim64_irq_ctrl_if #(.P_CH(4), .P_NUMW(3)) ifc ();

    utim64_irq_ctrl #(.P_CH(4), .P_NUMW(3)) dut (
        .iCLOCK  (clk),
        .inRESET (rst_n),
        .bus     (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] cmp;
        logic       cw;
        logic       ge;
        logic [3:0] msk;
        logic       clw;
        logic [3:0] clr;
        logic       ack;
        logic [3:0] pend;
        logic       vld;
        logic [2:0] num;
        logic       chk;
    } vec_t;

    vec_t vq[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic void add(input logic [3:0] cmp, input logic cw, input logic ge,
                                input logic [3:0] msk, input logic clw, input logic [3:0] clr,
                                input logic ack, input logic [3:0] pend, input logic vld,
                                input logic [2:0] num, input logic chk);
        vec_t v;
        v = '{cmp, cw, ge, msk, clw, clr, ack, pend, vld, num, chk};
        vq.push_back(v);
    endfunction

    task automatic check(input string what, input int id, input logic [31:0] act,
                         input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s #%0d: got %0h, expected %0h", what, id, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] cmp, input logic cw, input logic ge,
                         input logic [3:0] msk, input logic clw, input logic [3:0] clr,
                         input logic ack);
        ifc.iCMP_IRQ         = cmp;
        ifc.iCONF_WRITE      = cw;
        ifc.iCONF_GLOBAL_ENA = ge;
        ifc.iCONF_MASK       = msk;
        ifc.iCLR_WRITE       = clw;
        ifc.iCLR_PENDING     = clr;
        ifc.iIRQ_ACK         = ack;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0);

        //   cmp  cw ge msk  clw clr ack   pend vld num chk
        add(4'h0, 1, 1, 4'hF, 0, 4'h0, 0,  4'h0, 0, 0, 0); // basic request
        add(4'h4, 0, 0, 4'h0, 0, 4'h0, 0,  4'h4, 0, 0, 0);
        add(4'h0, 0, 0, 4'h0, 0, 4'h0, 0,  4'h4, 1, 2, 1);
        add(4'h0, 0, 0, 4'h0, 0, 4'h0, 0,  4'h4, 1, 2, 1);
        add(4'h0, 0, 0, 4'h0, 0, 4'h0, 1,  4'h0, 0, 0, 0);
        add(4'hA, 0, 0, 4'h0, 0, 4'h0, 0,  4'hA, 0, 0, 0); // priority
        add(4'h0, 0, 0, 4'h0, 0, 4'h0, 0,  4'hA, 1, 1, 1);
        add(4'h0, 0, 0, 4'h0, 0, 4'h0, 1,  4'h8, 0, 0, 0);
        add(4'h0, 0, 0, 4'h0, 0, 4'h0, 0,  4'h8, 1, 3, 1);
        add(4'h0, 0, 0, 4'h0, 0, 4'h0, 1,  4'h0, 0, 0, 0);
        add(4'h0, 1, 1, 4'h1, 0, 4'h0, 0,  4'h0, 0, 0, 0); // mask
        add(4'h4, 0, 0, 4'h0, 0, 4'h0, 0,  4'h4, 0, 0, 0);
        add(4'h0, 0, 0, 4'h0, 0, 4'h0, 0,  4'h4, 0, 0, 0);
        add(4'h0, 1, 1, 4'h5, 0, 4'h0, 0,  4'h4, 0, 0, 0);
        add(4'h0, 0, 0, 4'h0, 0, 4'h0, 0,  4'h4, 1, 2, 1);
        add(4'h0, 0, 0, 4'h0, 0, 4'h0, 1,  4'h0, 0, 0, 0);
        add(4'h1, 0, 0, 4'h0, 0, 4'h0, 0,  4'h1, 0, 0, 0); // request held
        add(4'h1, 0, 0, 4'h0, 0, 4'h0, 0,  4'h1, 1, 0, 1);
        add(4'h1, 1, 0, 4'h5, 1, 4'h1, 0,  4'h0, 1, 0, 1);
        add(4'h1, 0, 0, 4'h0, 0, 4'h0, 0,  4'h0, 1, 0, 1);
        add(4'h0, 0, 0, 4'h0, 0, 4'h0, 1,  4'h0, 0, 0, 0);
        add(4'h0, 0, 0, 4'h0, 0, 4'h0, 0,  4'h0, 0, 0, 0);
        add(4'h0, 1, 1, 4'hF, 0, 4'h0, 0,  4'h0, 0, 0, 0); // edge at ack
        add(4'h2, 0, 0, 4'h0, 0, 4'h0, 0,  4'h2, 0, 0, 0);
        add(4'h0, 0, 0, 4'h0, 0, 4'h0, 0,  4'h2, 1, 1, 1);
        add(4'h2, 0, 0, 4'h0, 0, 4'h0, 1,  4'h2, 0, 0, 0);
        add(4'h0, 0, 0, 4'h0, 0, 4'h0, 0,  4'h2, 1, 1, 1);
        add(4'h0, 0, 0, 4'h0, 0, 4'h0, 1,  4'h0, 0, 0, 0);
        add(4'h4, 0, 0, 4'h0, 0, 4'h0, 0,  4'h4, 0, 0, 0); // W1C vs edge
        add(4'h0, 0, 0, 4'h0, 0, 4'h0, 0,  4'h4, 1, 2, 1);
        add(4'h4, 0, 0, 4'h0, 1, 4'h4, 0,  4'h4, 1, 2, 1);
        add(4'h0, 0, 0, 4'h0, 0, 4'h0, 1,  4'h0, 0, 0, 0);
        add(4'h0, 0, 0, 4'h0, 0, 4'h0, 0,  4'h0, 0, 0, 0);

        tick();
        tick();
        check("reset_pending", 0, 32'(ifc.oPENDING), 32'h0);
        check("reset_valid",   0, 32'(ifc.oIRQ_VALID), 32'h0);
        check("reset_num",     0, 32'(ifc.oIRQ_NUM), 32'h0);
`ifdef UTIM64_IRQ_OVERRUN_EN
        check("reset_overrun", 0, 32'(ifc.oOVERRUN), 32'h0);
`endif
        rst_n = 1'b1;

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].cmp, vq[i].cw, vq[i].ge, vq[i].msk, vq[i].clw, vq[i].clr, vq[i].ack);
            tick();
            check("pending", i, 32'(ifc.oPENDING), 32'(vq[i].pend));
            check("valid",   i, 32'(ifc.oIRQ_VALID), 32'(vq[i].vld));
            if (vq[i].chk) begin
                check("num", i, 32'(ifc.oIRQ_NUM), 32'(vq[i].num));
            end
        end
`ifdef UTIM64_IRQ_OVERRUN_EN
        // No table vector loses an event: ack-edge and cleared-edge collisions
        check("table_overrun", 0, 32'(ifc.oOVERRUN), 32'h0);
`endif

        // Asynchronous reset in the middle of a request
        drive(4'h8, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0);
        tick();
        tick();
        check("pre_rst_valid", 0, 32'(ifc.oIRQ_VALID), 32'h1);
        check("pre_rst_num",   0, 32'(ifc.oIRQ_NUM), 32'h3);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_valid",   0, 32'(ifc.oIRQ_VALID), 32'h0);
        check("async_rst_pending", 0, 32'(ifc.oPENDING), 32'h0);
        check("async_rst_num",     0, 32'(ifc.oIRQ_NUM), 32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_edge", 0, 32'(ifc.oPENDING), 32'h8);
        tick();
        check("post_rst_mask", 0, 32'(ifc.oIRQ_VALID), 32'h0);

        // Two ch3 edges four cycles apart with no ack
        drive(4'h0, 1'b0, 1'b0, 4'h0, 1'b1, 4'h8, 1'b0);
        tick();
        check("clr_ch3", 0, 32'(ifc.oPENDING), 32'h0);
        drive(4'h8, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0);
        tick();
        drive(4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0);
        tick();
        tick();
        tick();
        drive(4'h8, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0);
        tick();
        check("second_edge_pending", 0, 32'(ifc.oPENDING), 32'h8);
`ifdef UTIM64_IRQ_OVERRUN_EN
        check("overrun_set", 0, 32'(ifc.oOVERRUN), 32'h8);
`endif
        drive(4'h0, 1'b0, 1'b0, 4'h0, 1'b1, 4'h8, 1'b0);
        tick();
        check("w1c_pending", 0, 32'(ifc.oPENDING), 32'h0);
`ifdef UTIM64_IRQ_OVERRUN_EN
        check("overrun_clr", 0, 32'(ifc.oOVERRUN), 32'h0);
`endif
        drive(4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
